// File: rtl/mm_pd_pkg.sv
// mm_pd_pkg: shared types and helpers for the Mueller-Muller phase detector.
// Holds the detector state enum, the hard sign decision and the accumulator
// width derivation used by mm_pd_decim and mm_pd_err.
package mm_pd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Hard decision from the sample sign bit: zero counts as positive.
    function automatic logic signed [1:0] sign_dec(input logic sign_bit);
        return sign_bit ? -2'sd1 : 2'sd1;
    endfunction

    // Accumulator must hold 2^dec_log2 errors of (adc_bit+1) bits each.
    function automatic int acc_bit_calc(input int adc_bit, input int dec_log2);
        return adc_bit + 1 + dec_log2;
    endfunction

endpackage

// File: rtl/mm_pd_err.sv
// mm_pd_err: combinational Mueller-Muller timing error
//   e[n] = d(x[n-1])*x[n] - d(x[n])*x[n-1]
// The result is ADC_BIT+1 bits; its magnitude never exceeds 2^(ADC_BIT-1),
// so modular arithmetic at that width yields the exact value.
module mm_pd_err
    import mm_pd_pkg::*;
#(
    parameter int ADC_BIT = 8
) (
    input  logic signed [ADC_BIT-1:0] x,
    input  logic signed [ADC_BIT-1:0] x_prev,
    output logic signed [ADC_BIT:0]   e
);

    logic signed [ADC_BIT:0] x_w;
    logic signed [ADC_BIT:0] xp_w;
    logic signed [ADC_BIT:0] t_cur;
    logic signed [ADC_BIT:0] t_prev;

    // Sign-weighted cross products and their difference.
    always_comb begin
        x_w    = {x[ADC_BIT-1], x};
        xp_w   = {x_prev[ADC_BIT-1], x_prev};
        t_cur  = (sign_dec(x_prev[ADC_BIT-1]) == 2'sd1) ? x_w : -x_w;
        t_prev = (sign_dec(x[ADC_BIT-1]) == 2'sd1) ? xp_w : -xp_w;
        e      = t_cur - t_prev;
    end

endmodule

// File: rtl/mm_pd_decim.sv
// mm_pd_decim: baud-rate Mueller-Muller timing-error detector with a
// decimating averager. Averages 2^DEC_LOG2 errors and emits one signed
// ADC_BIT-wide word with a one-cycle out_valid strobe; out is 0 otherwise.
// Optional feature: define MMPD_DEADZONE_EN to force averages with
// |avg| <= DZ_TH to zero on the strobe (the strobe still fires).
module mm_pd_decim
    import mm_pd_pkg::*;
#(
    parameter int ADC_BIT  = 8,
    parameter int DEC_LOG2 = 2,
    parameter int DZ_TH    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pd_en,
    input  logic                      in_valid,
    input  logic signed [ADC_BIT-1:0] in,
    output logic signed [ADC_BIT-1:0] out,
    output logic                      out_valid
);

    localparam int ACC_BIT = acc_bit_calc(ADC_BIT, DEC_LOG2);
    localparam logic [DEC_LOG2-1:0] CNT_MAX = '1;
    localparam logic signed [ACC_BIT-1:0] DZ_LIM = ACC_BIT'(DZ_TH);
`ifdef MMPD_DEADZONE_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    state_e state_q;
    state_e state_d;

    logic signed [ACC_BIT-1:0]  acc_q;
    logic [DEC_LOG2-1:0]        cnt_q;
    logic signed [ADC_BIT-1:0]  x_prev_q;
    logic signed [ADC_BIT-1:0]  out_p1;
    logic                       vld_p1;

    logic signed [ADC_BIT:0]    e_p0;
    logic signed [ACC_BIT-1:0]  sum_p0;

    logic clr;
    logic load;
    logic accum;
    logic strobe;

    // Floor average (arithmetic shift) with optional dead-zone squelch.
    // The averaged value always fits ADC_BIT, so truncation drops only sign copies.
    function automatic logic signed [ADC_BIT-1:0] avg_out(input logic signed [ACC_BIT-1:0] sum);
        logic signed [ACC_BIT-1:0] sh;
        logic signed [ACC_BIT-1:0] mag;
        sh  = sum >>> DEC_LOG2;
        mag = sh[ACC_BIT-1] ? -sh : sh;
        if (DZ_EN && (mag <= DZ_LIM)) begin
            return '0;
        end
        return sh[ADC_BIT-1:0];
    endfunction

    mm_pd_err #(
        .ADC_BIT(ADC_BIT)
    ) u_err (
        .x     (in),
        .x_prev(x_prev_q),
        .e     (e_p0)
    );

    // Running sum including the current error; used for both accumulate and dump.
    always_comb begin
        sum_p0 = acc_q + {{(ACC_BIT-ADC_BIT-1){e_p0[ADC_BIT]}}, e_p0};
    end

    // Next-state and datapath control; pd_en low dominates every state.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        load    = 1'b0;
        accum   = 1'b0;
        strobe  = 1'b0;
        if (!pd_en) begin
            state_d = IDLE;
            clr     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PRIME;
                end
                PRIME: begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        load   = 1'b1;
                        accum  = 1'b1;
                        strobe = (cnt_q == CNT_MAX);
                    end
                end
                default: begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stage p0 -> p1: accumulate errors, dump the average on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            x_prev_q <= '0;
            out_p1   <= '0;
            vld_p1   <= 1'b0;
        end else begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
            if (clr) begin
                acc_q    <= '0;
                cnt_q    <= '0;
                x_prev_q <= '0;
            end else begin
                if (load) begin
                    x_prev_q <= in;
                end
                if (accum) begin
                    if (strobe) begin
                        out_p1 <= avg_out(sum_p0);
                        vld_p1 <= 1'b1;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end else begin
                        acc_q  <= sum_p0;
                        cnt_q  <= cnt_q + DEC_LOG2'(1);
                    end
                end
            end
        end
    end

    assign out       = out_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_mm_pd_decim.sv
// tb_mm_pd_decim: directed bench for mm_pd_decim with a queue-based
// reference model of the averaged MM error and literal scenario results.
module tb_mm_pd_decim;
    import mm_pd_pkg::*;

    localparam int ADC_BIT  = 8;
    localparam int DEC_LOG2 = 2;
    localparam int DZ_TH    = 1;
    localparam int N        = 1 << DEC_LOG2;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic pd_en    = 1'b0;
    logic in_valid = 1'b0;
    logic signed [ADC_BIT-1:0] x_in = '0;
    logic signed [ADC_BIT-1:0] out_s;
    logic vld_s;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int   exp_out = 0;
    logic exp_vld = 1'b0;
    int   errs[$];
    int   prev      = 0;
    bit   have_prev = 1'b0;
    bit   armed     = 1'b0;

    int   strobes[$];

    mm_pd_decim #(
        .ADC_BIT (ADC_BIT),
        .DEC_LOG2(DEC_LOG2),
        .DZ_TH   (DZ_TH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pd_en    (pd_en),
        .in_valid (in_valid),
        .in       (x_in),
        .out      (out_s),
        .out_valid(vld_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int dsgn(input int v);
        return (v >= 0) ? 1 : -1;
    endfunction

    // floor(sum / N) with optional dead zone
    function automatic int model_avg(input int sum);
        int q;
        q = sum / N;
        if ((sum % N) != 0 && sum < 0) q = q - 1;
        assert (q >= -(2 ** (ADC_BIT - 1)) && q <= (2 ** (ADC_BIT - 1)) - 1)
            else $error("average %0d outside output range", q);
`ifdef MMPD_DEADZONE_EN
        if (q <= DZ_TH && q >= -DZ_TH) q = 0;
`endif
        return q;
    endfunction

    // Reference model: evaluates what each edge must produce.
    initial forever begin
        int xv;
        int e;
        int sum;
        @(posedge clk);
        exp_out = 0;
        exp_vld = 1'b0;
        xv = int'(x_in);
        if (rst || !pd_en) begin
            armed     = 1'b0;
            have_prev = 1'b0;
            errs.delete();
        end else if (!armed) begin
            armed = 1'b1;
        end else if (in_valid) begin
            if (!have_prev) begin
                prev      = xv;
                have_prev = 1'b1;
            end else begin
                e = dsgn(prev) * xv - dsgn(xv) * prev;
                errs.push_back(e);
                prev = xv;
                if (errs.size() == N) begin
                    sum = 0;
                    foreach (errs[i]) sum += errs[i];
                    exp_out = model_avg(sum);
                    exp_vld = 1'b1;
                    errs.delete();
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("cyc_out_valid", vld_s, exp_vld);
        chk("cyc_out", out_s, exp_out);
        if (vld_s === 1'b1) strobes.push_back(int'(out_s));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v, input int gap);
        x_in     = ADC_BIT'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x_in     = ADC_BIT'($urandom);
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic restart();
        pd_en = 1'b0;
        tick();
        pd_en = 1'b1;
        tick();
        strobes.delete();
    endtask

    task automatic expect_strobes(input string name, input int n, input int val);
        tick();
        tick();
        chk({name, "_count"}, strobes.size(), n);
        foreach (strobes[i]) chk({name, "_value"}, strobes[i], val);
    endtask

    initial begin
        int ramp[5];
        int negs[5];
        ramp = '{0, 4, 8, 12, 16};
        negs = '{-10, -9, -8, -7, -5};

        // reset held with detector enabled and random traffic
        rst   = 1'b1;
        pd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            x_in     = ADC_BIT'($urandom);
            tick();
            chk("rst_out", out_s, 0);
            chk("rst_out_valid", vld_s, 0);
        end
        chk("rst_state", dut.state_q, IDLE);
        rst      = 1'b0;
        in_valid = 1'b0;
        pd_en    = 1'b0;
        tick();

        // up-ramp, strobe visible right after the 16 sample edge
        restart();
        for (int i = 0; i < 4; i++) send(ramp[i], 0);
        chk("ramp_pre_valid", vld_s, 0);
        send(ramp[4], 0);
        chk("ramp_strobe_valid", vld_s, 1);
        chk("ramp_strobe_out", out_s, 4);
        tick();
        chk("ramp_after_valid", vld_s, 0);
        chk("ramp_after_out", out_s, 0);
        strobes.delete();
        strobes.push_back(4);
        expect_strobes("ramp", 1, 4);

        // negative average floors toward -inf
        restart();
        for (int i = 0; i < 5; i++) send(negs[i], 0);
        expect_strobes("neg_floor", 1, -2);

        // gapped valid
        restart();
        for (int i = 0; i < 5; i++) send(ramp[i], 2);
        expect_strobes("gapped", 1, 4);

        // pd_en drops on the edge of the final sample, then a fresh run
        restart();
        for (int i = 0; i < 4; i++) send(ramp[i], 0);
        x_in     = 8'sd16;
        in_valid = 1'b1;
        pd_en    = 1'b0;
        tick();
        in_valid = 1'b0;
        pd_en    = 1'b1;
        tick();
        chk("drop_no_strobe", strobes.size(), 0);
        for (int i = 0; i < 5; i++) send(ramp[i], 0);
        expect_strobes("drop_fresh", 1, 4);

        // constant input: zero error, strobe every four samples
        restart();
        for (int i = 0; i < 20; i++) send(20, 0);
        expect_strobes("const", 4, 0);

        // full-scale alternation
        restart();
        for (int i = 0; i < 5; i++) send((i % 2 == 0) ? -128 : 127, 0);
        expect_strobes("extreme", 1, 0);

        // reset mid-period discards the partial sum
        restart();
        for (int i = 0; i < 3; i++) send(ramp[i], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) send(ramp[i], 0);
        expect_strobes("rst_mid", 1, 4);

        // small average: squelched only with the dead zone enabled
        restart();
        for (int i = 0; i < 5; i++) send(i, 0);
`ifdef MMPD_DEADZONE_EN
        expect_strobes("deadzone", 1, 0);
`else
        expect_strobes("deadzone", 1, 1);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
